// File: rtl/if_fetch.sv
// IF-stage fetch sequencer: issues pc_i to instruction memory over req/gnt/rvalid and fills IF/ID.
// Optional skid buffer and HOLD state are built when IF_FETCH_SKID_EN is defined.
//
// state | meaning
// IDLE  | first cycle after reset, nothing issued
// REQ   | request driven at pc_i, waiting for gnt
// WAIT  | one request outstanding, waiting for rvalid
// HOLD  | response parked in skid buffer until IF/ID can load
module if_fetch #(
    parameter logic [29:0] START_ADDR = 30'h0000C00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] pc_i,
    output logic        pc_write_o,
    output logic        imem_req_o,
    output logic [29:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        id_stall_i,
    input  logic        flush_i,
    output logic        ifid_valid_o,
    output logic [29:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
`ifdef IF_FETCH_SKID_EN
        , ST_HOLD
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic        drop_q, drop_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [29:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        issue_ok;

`ifdef IF_FETCH_SKID_EN
    logic [29:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        can_load;

    assign can_load = !ifid_valid_q || !id_stall_i;
    assign issue_ok = 1'b1;
`else
    // Without a skid buffer the stall must be resolved before issuing,
    // so a response can always be written straight into IF/ID.
    assign issue_ok = !(ifid_valid_q && id_stall_i);
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        drop_d       = drop_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
`ifdef IF_FETCH_SKID_EN
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
`endif
        pc_write_o   = 1'b0;
        imem_req_o   = 1'b0;
        imem_addr_o  = addr_q;

        if (ifid_valid_q && !id_stall_i) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = '0;
        end

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                imem_addr_o = pc_i;
                imem_req_o  = issue_ok && !flush_i;
                // A gnt that coincides with a flush is still an issued request;
                // its response must be swallowed later.
                if (imem_gnt_i && (issue_ok || flush_i)) begin
                    addr_d  = pc_i;
                    drop_d  = flush_i;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    if (drop_q || flush_i) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end
`ifdef IF_FETCH_SKID_EN
                    else if (!can_load) begin
                        skid_pc_d    = addr_q;
                        skid_instr_d = imem_rdata_i;
                        state_d      = ST_HOLD;
                    end
`endif
                    else begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = addr_q;
                        ifid_instr_d = imem_rdata_i;
                        pc_write_o   = 1'b1;
                        state_d      = ST_REQ;
                    end
                end else if (flush_i) begin
                    drop_d = 1'b1;
                end
            end
`ifdef IF_FETCH_SKID_EN
            ST_HOLD: begin
                if (flush_i) begin
                    state_d = ST_REQ;
                end else if (can_load) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = skid_pc_q;
                    ifid_instr_d = skid_instr_q;
                    pc_write_o   = 1'b1;
                    state_d      = ST_REQ;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (flush_i) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = '0;
`ifdef IF_FETCH_SKID_EN
            skid_pc_d    = '0;
            skid_instr_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            drop_q       <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= START_ADDR;
            ifid_instr_q <= '0;
`ifdef IF_FETCH_SKID_EN
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            drop_q       <= drop_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
`ifdef IF_FETCH_SKID_EN
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
`endif
        end
    end

    assign ifid_valid_o = ifid_valid_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_instr_o = ifid_instr_q;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a PC register model plus scripted memory responses.
module tb_if_fetch;

    logic        clk;
    logic        reset;
    logic [29:0] pc_i;
    logic        pc_write_o;
    logic        imem_req_o;
    logic [29:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_stall_i;
    logic        flush_i;
    logic        ifid_valid_o;
    logic [29:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          pw_cnt = 0;
    logic [61:0] sb[$];
    logic        redir_en;
    logic [29:0] redir_pc;

    if_fetch #(.START_ADDR(30'h0000C00)) dut (
        .clk(clk), .reset(reset), .pc_i(pc_i), .pc_write_o(pc_write_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i), .id_stall_i(id_stall_i), .flush_i(flush_i),
        .ifid_valid_o(ifid_valid_o), .ifid_pc_o(ifid_pc_o), .ifid_instr_o(ifid_instr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register of the datapath: redirect wins over increment
    always @(posedge clk or posedge reset) begin
        if (reset) pc_i <= 30'h0000C00;
        else if (redir_en) pc_i <= redir_pc;
        else if (pc_write_o) pc_i <= pc_i + 30'd1;
    end

    always @(posedge clk) if (!reset && pc_write_o) pw_cnt <= pw_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Entered in REQ; leaves one cycle after rvalid with the IF/ID load checked.
    task automatic do_fetch(input int gnt_dly, input int rv_dly, input logic [31:0] data);
        logic [29:0] a;
        logic [61:0] e;
        a = pc_i;
        for (int i = 0; i < gnt_dly; i++) begin
            imem_gnt_i = 1'b0;
            #1;
            n_cmp++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== a) begin
                n_bad++;
                $display("FAIL fetch_req_hold: req=%b addr=%h, want req=1 addr=%h", imem_req_o, imem_addr_o, a);
            end
            cyc();
        end
        imem_gnt_i = 1'b1;
        #1;
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== a) begin
            n_bad++;
            $display("FAIL fetch_req_gnt: req=%b addr=%h, want req=1 addr=%h", imem_req_o, imem_addr_o, a);
        end
        cyc();
        imem_gnt_i = 1'b0;
        for (int i = 0; i < rv_dly - 1; i++) begin
            #1;
            n_cmp++;
            if (imem_req_o !== 1'b0 || pc_write_o !== 1'b0) begin
                n_bad++;
                $display("FAIL fetch_wait: req=%b pc_write=%b, want 0 0", imem_req_o, pc_write_o);
            end
            cyc();
        end
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
        sb.push_back({a, data});
        #1;
        n_cmp++;
        if (pc_write_o !== 1'b1) begin
            n_bad++;
            $display("FAIL fetch_pc_write: got %b want 1", pc_write_o);
        end
        cyc();
        imem_rvalid_i = 1'b0;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL fetch_sb_empty: got 0 entries want >=1");
        end else begin
            e = sb.pop_front();
            if (ifid_valid_o !== 1'b1 || ifid_pc_o !== e[61:32] || ifid_instr_o !== e[31:0]) begin
                n_bad++;
                $display("FAIL fetch_ifid: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                         ifid_valid_o, ifid_pc_o, ifid_instr_o, e[61:32], e[31:0]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ifid_valid_o !== 1'b0 || ifid_pc_o !== 30'hC00 || ifid_instr_o !== 32'h0 ||
            imem_req_o !== 1'b0 || imem_addr_o !== 30'h0 || pc_write_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: v=%b pc=%h ins=%h req=%b addr=%h pw=%b want 0 c00 0 0 0 0",
                     ifid_valid_o, ifid_pc_o, ifid_instr_o, imem_req_o, imem_addr_o, pc_write_o);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (imem_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_req: got %b want 0", imem_req_o);
        end
        cyc();
    endtask

    task automatic test_basic();
        int pw0;
        pw0 = pw_cnt;
        do_fetch(0, 1, 32'h2408_0005);
        #1;
        n_cmp++;
        if (pw_cnt - pw0 !== 1) begin
            n_bad++;
            $display("FAIL basic_pw_count: got %0d want 1", pw_cnt - pw0);
        end
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 30'hC01) begin
            n_bad++;
            $display("FAIL basic_next_req: req=%b addr=%h want 1 c01", imem_req_o, imem_addr_o);
        end
        do_fetch(0, 1, 32'h8C09_0004);
    endtask

    task automatic test_delay();
        int pw0;
        pw0 = pw_cnt;
        do_fetch(3, 2, 32'h0128_5020);
        n_cmp++;
        if (pw_cnt - pw0 !== 1) begin
            n_bad++;
            $display("FAIL delay_pw_count: got %0d want 1", pw_cnt - pw0);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        int pw0;
        do_fetch(0, 1, 32'h1111_0001);
        held = ifid_instr_o;
        id_stall_i = 1'b1;
        pw0 = pw_cnt;
`ifdef IF_FETCH_SKID_EN
        begin
            logic [29:0] a2;
            logic [61:0] e;
            a2 = pc_i;
            imem_gnt_i = 1'b1;
            #1;
            n_cmp++;
            if (imem_req_o !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_skid_issue: got %b want 1", imem_req_o);
            end
            cyc();
            imem_gnt_i    = 1'b0;
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'h2222_0002;
            sb.push_back({a2, 32'h2222_0002});
            cyc();
            imem_rvalid_i = 1'b0;
            for (int i = 0; i < 2; i++) begin
                #1;
                n_cmp++;
                if (pc_write_o !== 1'b0 || imem_req_o !== 1'b0 || ifid_instr_o !== held) begin
                    n_bad++;
                    $display("FAIL stall_hold: pw=%b req=%b ins=%h want 0 0 %h", pc_write_o, imem_req_o, ifid_instr_o, held);
                end
                cyc();
            end
            n_cmp++;
            if (pw_cnt !== pw0) begin
                n_bad++;
                $display("FAIL stall_no_pw: got %0d want %0d", pw_cnt, pw0);
            end
            id_stall_i = 1'b0;
            #1;
            n_cmp++;
            if (pc_write_o !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_release_pw: got %b want 1", pc_write_o);
            end
            cyc();
            n_cmp++;
            e = sb.pop_front();
            if (ifid_valid_o !== 1'b1 || ifid_pc_o !== e[61:32] || ifid_instr_o !== e[31:0]) begin
                n_bad++;
                $display("FAIL stall_skid_load: v=%b pc=%h ins=%h want 1 %h %h", ifid_valid_o, ifid_pc_o, ifid_instr_o, e[61:32], e[31:0]);
            end
        end
`else
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (imem_req_o !== 1'b0 || pc_write_o !== 1'b0 || ifid_instr_o !== held || ifid_valid_o !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_block: req=%b pw=%b v=%b ins=%h want 0 0 1 %h",
                         imem_req_o, pc_write_o, ifid_valid_o, ifid_instr_o, held);
            end
            cyc();
        end
        n_cmp++;
        if (pw_cnt !== pw0) begin
            n_bad++;
            $display("FAIL stall_no_pw: got %0d want %0d", pw_cnt, pw0);
        end
        id_stall_i = 1'b0;
        do_fetch(0, 1, 32'h2222_0002);
`endif
    endtask

    task automatic test_flush_wait();
        int pw0;
        pw0 = pw_cnt;
        imem_gnt_i = 1'b1;
        cyc();
        imem_gnt_i = 1'b0;
        flush_i    = 1'b1;
        redir_en   = 1'b1;
        redir_pc   = 30'h100;
        #1;
        n_cmp++;
        if (pc_write_o !== 1'b0 || imem_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_wait_mask: pw=%b req=%b want 0 0", pc_write_o, imem_req_o);
        end
        cyc();
        flush_i  = 1'b0;
        redir_en = 1'b0;
        cyc();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (pc_write_o !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_drop_pw: got %b want 0", pc_write_o);
        end
        cyc();
        imem_rvalid_i = 1'b0;
        n_cmp++;
        if (ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0 || imem_req_o !== 1'b1 || imem_addr_o !== 30'h100) begin
            n_bad++;
            $display("FAIL flush_after: v=%b ins=%h req=%b addr=%h want 0 0 1 100",
                     ifid_valid_o, ifid_instr_o, imem_req_o, imem_addr_o);
        end
        n_cmp++;
        if (pw_cnt !== pw0) begin
            n_bad++;
            $display("FAIL flush_pw_count: got %0d want %0d", pw_cnt, pw0);
        end
        do_fetch(1, 1, 32'h3C01_1234);
    endtask

    task automatic test_flush_gnt_stall();
        id_stall_i = 1'b1;
        flush_i    = 1'b1;
        imem_gnt_i = 1'b1;
        redir_en   = 1'b1;
        redir_pc   = 30'h200;
        #1;
        n_cmp++;
        if (pc_write_o !== 1'b0 || imem_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL fgs_mask: pw=%b req=%b want 0 0", pc_write_o, imem_req_o);
        end
        cyc();
        flush_i    = 1'b0;
        imem_gnt_i = 1'b0;
        redir_en   = 1'b0;
        n_cmp++;
        if (ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0) begin
            n_bad++;
            $display("FAIL fgs_clear: v=%b ins=%h want 0 0", ifid_valid_o, ifid_instr_o);
        end
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h1234_5678;
        #1;
        n_cmp++;
        if (pc_write_o !== 1'b0) begin
            n_bad++;
            $display("FAIL fgs_drop_pw: got %b want 0", pc_write_o);
        end
        cyc();
        imem_rvalid_i = 1'b0;
        n_cmp++;
        if (ifid_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 30'h200) begin
            n_bad++;
            $display("FAIL fgs_after: v=%b req=%b addr=%h want 0 1 200", ifid_valid_o, imem_req_o, imem_addr_o);
        end
        id_stall_i = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        imem_gnt_i = 1'b1;
        cyc();
        imem_gnt_i = 1'b0;
        reset      = 1'b1;
        #1;
        n_cmp++;
        if (ifid_valid_o !== 1'b0 || ifid_pc_o !== 30'hC00 || ifid_instr_o !== 32'h0 ||
            imem_req_o !== 1'b0 || imem_addr_o !== 30'h0 || pc_write_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_wait_values: v=%b pc=%h ins=%h req=%b addr=%h pw=%b want 0 c00 0 0 0 0",
                     ifid_valid_o, ifid_pc_o, ifid_instr_o, imem_req_o, imem_addr_o, pc_write_o);
        end
        cyc();
        reset         = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_0BAD;
        #1;
        n_cmp++;
        if (pc_write_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_stale_pw: got %b want 0", pc_write_o);
        end
        cyc();
        imem_rvalid_i = 1'b0;
        n_cmp++;
        if (ifid_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 30'hC00) begin
            n_bad++;
            $display("FAIL rst_after: v=%b req=%b addr=%h want 0 1 c00", ifid_valid_o, imem_req_o, imem_addr_o);
        end
        do_fetch(0, 1, 32'h2408_0005);
    endtask

    initial begin
        reset         = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        id_stall_i    = 1'b0;
        flush_i       = 1'b0;
        redir_en      = 1'b0;
        redir_pc      = 30'h0;
        test_reset();
        test_basic();
        test_delay();
        test_stall();
        test_flush_wait();
        test_flush_gnt_stall();
        test_reset_mid_wait();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
